// File: rtl/demux_dispatch_controller.sv
// Dispatch controller for the 4-way destination demux: buffers {dest, data} words in a
// small FIFO and drives registered dm_data/dm_sel/dm_enable with minimum hold and ack timeout.
module demux_dispatch_controller #(
    parameter int DATA_W      = 4,
    parameter int FIFO_DEPTH  = 4,
    parameter int HOLD_CYCLES = 3,
    parameter int TIMEOUT     = 15
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [DATA_W-1:0]             in_data,
    input  logic [1:0]                    in_dest,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [3:0]                    dest_ack,
    output logic [DATA_W-1:0]             dm_data,
    output logic [1:0]                    dm_sel,
    output logic                          dm_enable,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic [7:0]                    drop_count
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = $clog2(TIMEOUT) + 1;
    localparam logic [PTR_W:0]   FULL_CNT  = (PTR_W+1)'(FIFO_DEPTH);
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] TMO_LAST  = CNT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, DRIVE, GAP} state_t;

    state_t              state_q, state_d;
    logic [DATA_W+1:0]   mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]    wr_ptr_q, rd_ptr_q;
    logic [PTR_W:0]      count_q, count_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                ack_seen_q, ack_seen_d;
    logic [DATA_W-1:0]   dm_data_q, dm_data_d;
    logic [1:0]          dm_sel_q, dm_sel_d;
    logic                dm_enable_q, dm_enable_d;
    logic [7:0]          drop_q, drop_d;
    logic                full, empty, push, pop, ack_now, ack_any;
    logic [DATA_W+1:0]   head;

    assign full     = (count_q == FULL_CNT);
    assign empty    = (count_q == '0);
    assign in_ready = !full;
    assign push     = in_valid && !full;
    assign head     = mem_q[rd_ptr_q];
    assign ack_now  = dest_ack[dm_sel_q];
    assign ack_any  = ack_seen_q || ack_now;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        ack_seen_d  = ack_seen_q;
        dm_data_d   = dm_data_q;
        dm_sel_d    = dm_sel_q;
        dm_enable_d = 1'b0;
        drop_d      = drop_q;
        pop         = 1'b0;
        case (state_q)
            IDLE: begin
                if (!empty) begin
                    pop         = 1'b1;
                    dm_data_d   = head[DATA_W-1:0];
                    dm_sel_d    = head[DATA_W+1:DATA_W];
                    cnt_d       = '0;
                    ack_seen_d  = 1'b0;
                    dm_enable_d = 1'b1;
                    state_d     = DRIVE;
                end
            end
            DRIVE: begin
                dm_enable_d = 1'b1;
                cnt_d       = cnt_q + 1'b1;
                ack_seen_d  = ack_any;
                // Delivery is checked first so a late ack on the timeout edge still counts.
                if (cnt_q >= HOLD_LAST && ack_any) begin
                    dm_enable_d = 1'b0;
                    dm_data_d   = '0;
                    state_d     = GAP;
                end else if (cnt_q == TMO_LAST) begin
                    dm_enable_d = 1'b0;
                    dm_data_d   = '0;
                    state_d     = GAP;
                    if (drop_q != 8'hFF) drop_d = drop_q + 1'b1;
                end
            end
            GAP:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            cnt_q       <= '0;
            ack_seen_q  <= 1'b0;
            dm_data_q   <= '0;
            dm_sel_q    <= 2'b00;
            dm_enable_q <= 1'b0;
            drop_q      <= '0;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            cnt_q       <= cnt_d;
            ack_seen_q  <= ack_seen_d;
            dm_data_q   <= dm_data_d;
            dm_sel_q    <= dm_sel_d;
            dm_enable_q <= dm_enable_d;
            drop_q      <= drop_d;
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
        end
    end

    // Storage needs no reset; occupancy alone decides what is valid.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= {in_dest, in_data};
    end

    assign dm_data    = dm_data_q;
    assign dm_sel     = dm_sel_q;
    assign dm_enable  = dm_enable_q;
    assign fifo_count = count_q;
    assign drop_count = drop_q;
    assign busy       = (state_q != IDLE) || !empty;

endmodule

// File: tb/tb_demux_dispatch_controller.sv
// Scoreboard bench for demux_dispatch_controller: stimulus queues expected enable bursts,
// a negedge monitor measures each burst (data, sel, length, gap) and compares.
module tb_demux_dispatch_controller;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] in_data;
    logic [1:0] in_dest;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] dest_ack;
    logic [3:0] dm_data;
    logic [1:0] dm_sel;
    logic       dm_enable;
    logic       busy;
    logic [2:0] fifo_count;
    logic [7:0] drop_count;

    demux_dispatch_controller #(
        .DATA_W(4), .FIFO_DEPTH(4), .HOLD_CYCLES(3), .TIMEOUT(15)
    ) dut (
        .clk(clk), .reset(reset),
        .in_data(in_data), .in_dest(in_dest), .in_valid(in_valid), .in_ready(in_ready),
        .dest_ack(dest_ack),
        .dm_data(dm_data), .dm_sel(dm_sel), .dm_enable(dm_enable),
        .busy(busy), .fifo_count(fifo_count), .drop_count(drop_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] data;
        logic [1:0] sel;
        int         len;
    } exp_t;

    exp_t exp_q[$];
    int   errors = 0;
    int   checks = 0;

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: actual=%0d required=%0d at %0t", name, act, req, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // len==0 means the word is expected to be lost (reset test), so nothing is queued.
    task automatic push(input logic [3:0] d, input logic [1:0] s, input int len);
        int w;
        exp_t e;
        w = 0;
        while (!in_ready && w < 200) begin
            tick();
            w++;
        end
        if (!in_ready) begin
            chk("push_wait_ready", 0, 1);
        end else begin
            in_data  = d;
            in_dest  = s;
            in_valid = 1'b1;
            if (len > 0) begin
                e.data = d; e.sel = s; e.len = len;
                exp_q.push_back(e);
            end
            tick();
            in_valid = 1'b0;
        end
    endtask

    task automatic wait_idle(input int bound, output int n);
        n = 0;
        while (busy && n < bound) begin
            tick();
            n++;
        end
        chk("idle_reached", int'(busy), 0);
    endtask

    // Monitor: one burst = consecutive dm_enable cycles; the first low cycle after it is GAP.
    logic       in_burst = 1'b0;
    int         b_len;
    logic [3:0] b_data;
    logic [1:0] b_sel;

    always @(negedge clk) begin
        exp_t e;
        if (reset) begin
            in_burst = 1'b0;
        end else if (dm_enable) begin
            if (!in_burst) begin
                in_burst = 1'b1;
                b_len    = 0;
                b_data   = dm_data;
                b_sel    = dm_sel;
            end else if (dm_data != b_data || dm_sel != b_sel) begin
                chk("burst_stable", int'({dm_sel, dm_data}), int'({b_sel, b_data}));
            end
            b_len++;
        end else if (in_burst) begin
            in_burst = 1'b0;
            if (exp_q.size() == 0) begin
                chk("unexpected_burst_data", int'(b_data), -1);
            end else begin
                e = exp_q.pop_front();
                chk("burst_data", int'(b_data), int'(e.data));
                chk("burst_sel", int'(b_sel), int'(e.sel));
                chk("burst_len", b_len, e.len);
            end
            chk("gap_data_zero", int'(dm_data), 0);
            chk("gap_sel_held", int'(dm_sel), int'(b_sel));
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, errors=%0d", errors);
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        reset    = 1'b1;
        in_valid = 1'b0;
        in_data  = 4'h0;
        in_dest  = 2'b00;
        dest_ack = 4'h0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_enable", int'(dm_enable), 0);
        chk("rst_data", int'(dm_data), 0);
        chk("rst_sel", int'(dm_sel), 0);
        chk("rst_fifo_count", int'(fifo_count), 0);
        chk("rst_in_ready", int'(in_ready), 1);
        chk("rst_busy", int'(busy), 0);
        chk("rst_drop", int'(drop_count), 0);
        reset = 1'b0;
        tick();

        // Reset asserted asynchronously mid-DRIVE with two words queued.
        push(4'h1, 2'b00, 0);
        push(4'h2, 2'b01, 0);
        push(4'h3, 2'b10, 0);
        tick();
        chk("pre_reset_enable", int'(dm_enable), 1);
        chk("pre_reset_count", int'(fifo_count), 2);
        #1 reset = 1'b1;
        #1;
        chk("async_rst_enable", int'(dm_enable), 0);
        chk("async_rst_data", int'(dm_data), 0);
        chk("async_rst_sel", int'(dm_sel), 0);
        chk("async_rst_count", int'(fifo_count), 0);
        chk("async_rst_in_ready", int'(in_ready), 1);
        chk("async_rst_busy", int'(busy), 0);
        tick();
        tick();
        reset = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("post_reset_no_enable", int'(dm_enable), 0);
        end

        // Single delivery with ack held high.
        dest_ack = 4'hF;
        push(4'hA, 2'b10, 3);
        wait_idle(50, n);
        chk("single_drop", int'(drop_count), 0);

        // Late ack in DRIVE cycle 6.
        dest_ack = 4'h0;
        push(4'h5, 2'b01, 7);
        tick();
        repeat (6) tick();
        dest_ack = 4'b0010;
        tick();
        dest_ack = 4'h0;
        wait_idle(50, n);

        // Wrong-destination ack pulses, then the next word delivers.
        push(4'h7, 2'b00, 15);
        push(4'h9, 2'b01, 3);
        for (int i = 0; i < 14; i++) begin
            dest_ack = (i % 2 == 1) ? 4'b1000 : 4'b0000;
            tick();
        end
        dest_ack = 4'h0;
        tick();
        dest_ack = 4'hF;
        wait_idle(50, n);
        chk("wrong_dest_drop", int'(drop_count), 1);

        // FIFO full, rejected fifth word, in-order delivery at 5 cycles per word.
        dest_ack = 4'h0;
        push(4'hE, 2'b11, 5);
        push(4'h1, 2'b00, 3);
        push(4'h2, 2'b01, 3);
        push(4'h3, 2'b10, 3);
        push(4'h4, 2'b11, 3);
        chk("full_count", int'(fifo_count), 4);
        chk("full_in_ready", int'(in_ready), 0);
        in_data  = 4'h5;
        in_dest  = 2'b00;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        chk("full_reject_count", int'(fifo_count), 4);
        dest_ack = 4'hF;
        wait_idle(100, n);
        chk("drain_cycles", n, 22);
        chk("drain_drop", int'(drop_count), 1);

        // Early single-cycle ack in DRIVE cycle 0.
        dest_ack = 4'h0;
        push(4'h3, 2'b01, 3);
        tick();
        dest_ack = 4'b0010;
        tick();
        dest_ack = 4'h0;
        wait_idle(50, n);

        // 260 timeouts: drop_count saturates.
        for (int i = 0; i < 260; i++) begin
            push(4'(i), 2'(i), 15);
        end
        wait_idle(6000, n);
        chk("drop_saturated", int'(drop_count), 255);

        repeat (3) tick();
        chk("scoreboard_empty", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/demux_dispatch_controller.md
Name: demux_dispatch_controller

Overview:
Sequences the 4-way destination demultiplexer (lib/fire/school/shack). Upstream producers push {data, destination} words into a small FIFO. The controller pops one word at a time and drives the demux data, select and enable. It holds each word for a minimum number of cycles and waits for the selected destination's acknowledge. A word is dropped on timeout. It sits directly in front of the demux instance and owns its sel/enable inputs.

Parameters:
DATA_W, 4, width of payload (matches demux dataIn)
FIFO_DEPTH, 4, entries in input FIFO (power of 2, >=2)
HOLD_CYCLES, 3, minimum cycles dm_enable stays high per word (>=1)
TIMEOUT, 15, max cycles in DRIVE before drop (must be > HOLD_CYCLES)

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high reset
in_data  in  DATA_W  payload from producer
in_dest  in  2  destination: 00 lib, 01 fire, 10 school, 11 shack
in_valid  in  1  producer has a word
in_ready  out  1  FIFO can accept (= !full)
dest_ack  in  4  per-destination acknowledge, bit index = destination code
dm_data  out  DATA_W  to demux dataIn
dm_sel  out  2  to demux sel
dm_enable  out  1  to demux enable
busy  out  1  state != IDLE or FIFO non-empty
fifo_count  out  clog2(FIFO_DEPTH)+1  current FIFO occupancy
drop_count  out  8  words dropped on timeout, saturating

Behaviour:
- Reset (async, any time including mid-transfer): state=IDLE, FIFO emptied, fifo_count=0, dm_enable=0, dm_data=0, dm_sel=00, drop_count=0, busy=0, in_ready=1, hold/timeout counter=0, ack_seen=0.
- FIFO push: on rising edge when in_valid & in_ready. in_ready=!full is combinational from occupancy only. No push when full, even if a pop happens the same cycle. Push and pop in the same edge (not full) leaves the count unchanged. Words leave the FIFO in order.
- FSM states: IDLE, DRIVE, GAP.
- IDLE:
  - dm_enable=0.
  - If the FIFO is non-empty: pop the head into the holding register (dm_data, dm_sel), clear the counter and ack_seen, and go to DRIVE.
  - Otherwise stay in IDLE.
- DRIVE:
  - dm_enable=1; dm_data and dm_sel are stable from the holding register.
  - The counter increments each cycle, starting at 0.
  - ack_seen is set when dest_ack[dm_sel] is high. dest_ack bits for non-selected destinations are ignored.
  - Deliver exit: at an edge where counter >= HOLD_CYCLES-1 and (ack_seen | dest_ack[dm_sel]), go to GAP.
  - Drop exit: otherwise, at an edge where counter == TIMEOUT-1, go to GAP and increment drop_count (saturates at 255).
  - Delivery takes priority over drop when both are true on the same edge.
- GAP:
  - One cycle with dm_enable=0 and dm_data=0; dm_sel holds its last value.
  - Then unconditionally go to IDLE.
- All dm_* outputs are registered, so the demux never sees glitches.
- Latency: a push at edge k into an empty FIFO while IDLE gives a pop at edge k+1, with dm_enable high from edge k+1.
- Enable duration:
  - With ack already high, dm_enable stays high for exactly HOLD_CYCLES cycles.
  - On drop, dm_enable stays high for exactly TIMEOUT cycles.
- Back-to-back throughput with immediate ack: one word per HOLD_CYCLES+2 cycles (DRIVE, GAP, IDLE).
- An early ack (before the counter reaches HOLD_CYCLES-1) is remembered via ack_seen. The ack does not need to be held.
- in_dest and in_data are captured atomically at push; there is no cross-word mixing.
- fifo_count wraps never; pointers wrap modulo FIFO_DEPTH.

Test Plan:
- Reset state: assert reset mid-DRIVE with 2 words queued -> outputs immediately 0 (async), fifo_count=0, in_ready=1, and no dm_enable after release until a new push.
- Single delivery, ack tied high: push data=4'hA, dest=10 -> dm_enable high for exactly 3 cycles with dm_sel=10, dm_data=A. Then 1 GAP cycle with dm_data=0, then idle; drop_count=0.
- Late ack: push data=5, dest=01, and assert dest_ack[1] only in DRIVE cycle 6 -> dm_enable high 7 cycles, then GAP.
- Wrong-destination ack: dest=00 while only dest_ack[3] pulses -> timeout after 15 cycles, drop_count=1. The next queued word then dispatches normally.
- FIFO full and order: push 4 words (dest 00,01,10,11, data 1,2,3,4) with acks held low briefly -> in_ready=0 after the 4th push and a 5th in_valid is not accepted. Once acks are high, the words are delivered in order 1,2,3,4 at one word per 5 cycles.
- Early ack and saturation: a single-cycle ack pulse in DRIVE cycle 0 -> exit still after 3 cycles. Forcing 260 timeouts -> drop_count holds at 255.
